scm_fifo_ctrl: RTL and testbench
================================

SCM_FIFO_CTRL -- requirements
Module: scm_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register-file address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 The block SHALL have one clock, clk, with a synchronous active-high reset, rst.
REQ-004 The block SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have the push ports: in_valid  in  1; in_ready  out  1; in_data  in  DATA_WIDTH.
REQ-006 The block SHALL have the pop ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH.
REQ-007 The block SHALL have the register-file write ports: rf_we  out  1; rf_waddr  out  ADDR_WIDTH; rf_wdata  out  DATA_WIDTH.
REQ-008 The block SHALL have the register-file read ports: rf_re  out  1; rf_raddr  out  ADDR_WIDTH; rf_rdata  in  DATA_WIDTH (valid the cycle after rf_re, held until the next rf_re).
REQ-009 The block SHALL have the status ports: count  out  ADDR_WIDTH+1  occupied entries; full  out  1; empty  out  1.

Function
REQ-010 The block SHALL form a DEPTH-entry FIFO around an external 1R1W latch/flop register file with a registered read address.
REQ-011 in_ready SHALL be 1 exactly when count < DEPTH and rst=0; the push handshake SHALL be in_valid && in_ready.
REQ-012 rf_we SHALL equal the push handshake, with rf_waddr = wr_ptr and rf_wdata = in_data (combinational), and wr_ptr SHALL increment modulo DEPTH on each push.
REQ-013 pending (written, not yet read-issued) SHALL be count - out_valid.
REQ-014 rf_re SHALL be 1 when pending != 0 && (!out_valid || out_ready), with rf_raddr = rd_ptr; rd_ptr SHALL increment modulo DEPTH on each rf_re.
REQ-015 out_valid SHALL be set in the cycle after rf_re, and SHALL be cleared after a pop handshake (out_valid && out_ready) with no concurrent rf_re.
REQ-016 out_data SHALL equal rf_rdata; while out_valid && !out_ready, out_data SHALL stay stable because rf_re=0 and that entry remains counted.
REQ-017 count SHALL increase by 1 on a push, decrease by 1 on a pop, and be unchanged on a simultaneous push and pop; the displayed entry SHALL be counted until popped.
REQ-018 full SHALL be (count == DEPTH) and empty SHALL be (count == 0).
REQ-019 Latency from a push into an empty FIFO to out_valid SHALL be 2 cycles (write edge, then read-address edge); there SHALL be no write-to-read bypass.
REQ-020 Sustained throughput SHALL be 1 word/cycle when in_valid=out_ready=1 and count >= 2.
REQ-021 Pushes while full SHALL be blocked (rf_we=0); pop when empty SHALL be impossible (out_valid=0).
REQ-022 A push at full with a simultaneous pop SHALL not be accepted, because in_ready depends only on count.
REQ-023 Both pointers SHALL wrap from DEPTH-1 to 0 with no extra state bit; full and empty SHALL derive from count only.

Reset
REQ-024 While rst=1 at a clk edge, wr_ptr, rd_ptr and count SHALL become 0 and out_valid SHALL become 0.
REQ-025 While rst=1, in_ready, rf_we and rf_re SHALL be 0.
REQ-026 After reset, empty=1, full=0 and count=0.
REQ-027 Reset mid-transfer SHALL discard all contents; register-file contents SHALL not be cleared and are don't-care.

Configuration
REQ-028 With SCM_FIFO_FLUSH_EN defined, the block SHALL have an additional input flush (1 bit) that has reset-equivalent effect on pointers, count and out_valid at the next edge.
REQ-029 In the flush cycle, in_ready, rf_we and rf_re SHALL be 0, so a push or pop offered in that cycle is not accepted.
REQ-030 Without SCM_FIFO_FLUSH_EN, the flush port and its logic SHALL be absent.

Verification (ADDR_WIDTH=2, DEPTH=4, paired with a 1R1W register-file model)
REQ-031 Reset -> count=0, empty=1, full=0, out_valid=0, rf_we=0, rf_re=0.
REQ-032 Push 0xA5 once into empty, out_ready=0 -> rf_we@c0 waddr=0, rf_re@c1 raddr=0, out_valid@c2 with out_data=0xA5, held stable 5 cycles.
REQ-033 Push 0x1..0x5 back-to-back with out_ready=0 -> four accepted, full=1 and in_ready=0 on the fifth; then drain -> outputs 0x1,0x2,0x3,0x4 in order.
REQ-034 Streaming 20 words with in_valid=out_ready=1 -> pointers wrap 3->0 repeatedly, output order is preserved, 1 word/cycle after 2-cycle fill.
REQ-035 At full, assert push and pop simultaneously -> pop accepted, push rejected, count 4->3; the next cycle the push is accepted.
REQ-036 (SCM_FIFO_FLUSH_EN) With 3 entries, pulse flush together with in_valid=1 -> next cycle count=0, out_valid=0, and nothing written.

Source files
------------

// File: rtl/scm_fifo_ctrl.sv
// FIFO controller wrapping an external 1R1W register file with a registered read port.
// Optional flush input is compiled in when SCM_FIFO_FLUSH_EN is defined.
module scm_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SCM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_re,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] DepthC = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH:0]   pending;
    logic                  clear;
    logic                  push;
    logic                  pop;

`ifdef SCM_FIFO_FLUSH_EN
    assign clear = rst | flush;
`else
    assign clear = rst;
`endif

    // Ready depends on count alone, so a push at full is refused even alongside a pop.
    assign in_ready = !clear && (count < DepthC);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Entries written but not yet sent to the read port; the displayed word stays in count.
    assign pending  = count - {{ADDR_WIDTH{1'b0}}, out_valid};

    assign rf_we    = push;
    assign rf_waddr = wrPtr;
    assign rf_wdata = in_data;
    assign rf_re    = !clear && (pending != '0) && (!out_valid || out_ready);
    assign rf_raddr = rdPtr;
    assign out_data = rf_rdata;

    assign full     = (count == DepthC);
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (rf_re)
                rdPtr <= rdPtr + 1'b1;
            if (rf_re)
                out_valid <= 1'b1;
            else if (pop)
                out_valid <= 1'b0;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed bench for scm_fifo_ctrl at DEPTH=4 with a behavioural 1R1W register file.
module tb_scm_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
`ifdef SCM_FIFO_FLUSH_EN
    logic          flush = 1'b0;
`endif
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_re;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
`ifdef SCM_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .count(count), .full(full), .empty(empty)
    );

    // Register-file model: write at the edge, read data registered and held until next read.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        if (rf_re) rf_rdata <= mem[rf_raddr];
    end

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic [2:0] cnt;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic       we;
        logic [1:0] wa;
        logic       re;
        logic [1:0] ra;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic [2:0] cnt, input logic ov, input logic [7:0] od,
                                input logic ir, input logic we, input logic [1:0] wa,
                                input logic re, input logic [1:0] ra);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.cnt = cnt; v.ov = ov; v.od = od;
        v.ir = ir; v.we = we; v.wa = wa; v.re = re; v.ra = ra;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    task automatic checkVec(input vec_t v, input int idx);
        chk("count", idx, 32'(count), 32'(v.cnt));
        chk("out_valid", idx, 32'(out_valid), 32'(v.ov));
        if (v.ov) chk("out_data", idx, 32'(out_data), 32'(v.od));
        chk("in_ready", idx, 32'(in_ready), 32'(v.ir));
        chk("rf_we", idx, 32'(rf_we), 32'(v.we));
        if (v.we) begin
            chk("rf_waddr", idx, 32'(rf_waddr), 32'(v.wa));
            chk("rf_wdata", idx, 32'(rf_wdata), 32'(v.id));
        end
        chk("rf_re", idx, 32'(rf_re), 32'(v.re));
        if (v.re) chk("rf_raddr", idx, 32'(rf_raddr), 32'(v.ra));
        chk("full", idx, 32'(full), 32'(v.cnt == 3'd4));
        chk("empty", idx, 32'(empty), 32'(v.cnt == 3'd0));
    endtask

    initial begin
        int popIdx;
        int k;
        logic [7:0] exp35 [4];

        //                iv  id     ordy cnt ov od     ir we wa re ra
        vt[0]  = mk(1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        vt[1]  = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        vt[2]  = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        vt[3]  = vt[2];
        vt[4]  = vt[2];
        vt[5]  = vt[2];
        vt[6]  = vt[2];
        vt[7]  = mk(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        vt[8]  = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        vt[9]  = mk(1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        vt[10] = mk(1'b1, 8'h02, 1'b0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1);
        vt[11] = mk(1'b1, 8'h03, 1'b0, 3'd2, 1'b1, 8'h01, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
        vt[12] = mk(1'b1, 8'h04, 1'b0, 3'd3, 1'b1, 8'h01, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        vt[13] = mk(1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        vt[14] = mk(1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        vt[15] = mk(1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h02, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
        vt[16] = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h03, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        vt[17] = mk(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h04, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        vt[18] = mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);

        // Reset with traffic offered: nothing may be accepted or issued.
        drive(1'b1, 1'b1, 8'hEE, 1'b1);
        drive(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
        chk("rst_rf_we", 0, 32'(rf_we), 32'd0);
        chk("rst_rf_re", 0, 32'(rf_re), 32'd0);
        chk("rst_count", 0, 32'(count), 32'd0);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);

        // Single push latency/hold, then fill-to-full and in-order drain.
        foreach (vt[i]) begin
            drive(1'b0, vt[i].iv, vt[i].id, vt[i].ordy);
            checkVec(vt[i], i);
        end

        // Streaming 20 words: first pop at cycle 2, then one per cycle in order.
        popIdx = 0;
        for (int t = 0; t < 30; t++) begin
            drive(1'b0, t < 20, 8'(8'h60 + t), 1'b1);
            if (t < 20) chk("stream_in_ready", t, 32'(in_ready), 32'd1);
            if (out_valid === 1'b1) begin
                chk("stream_data", popIdx, 32'(out_data), 32'(8'h60 + popIdx));
                chk("stream_cycle", popIdx, t, popIdx + 2);
                popIdx++;
            end
        end
        chk("stream_pops", 0, popIdx, 20);

        // Push and pop together at full: pop accepted, push refused, then accepted next cycle.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
        drive(1'b0, 1'b1, 8'h35, 1'b1);
        chk("full_count", 0, 32'(count), 32'd4);
        chk("full_in_ready", 0, 32'(in_ready), 32'd0);
        chk("full_rf_we", 0, 32'(rf_we), 32'd0);
        chk("full_out_data", 0, 32'(out_data), 32'h31);
        drive(1'b0, 1'b1, 8'h35, 1'b0);
        chk("after_pop_count", 0, 32'(count), 32'd3);
        chk("after_pop_in_ready", 0, 32'(in_ready), 32'd1);
        chk("after_pop_rf_we", 0, 32'(rf_we), 32'd1);
        exp35[0] = 8'h32; exp35[1] = 8'h33; exp35[2] = 8'h34; exp35[3] = 8'h35;
        k = 0;
        for (int t = 0; t < 20 && k < 4; t++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid === 1'b1) begin
                chk("full_drain", k, 32'(out_data), 32'(exp35[k]));
                k++;
            end
        end
        chk("full_drain_n", 0, k, 4);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_drain_empty", 0, 32'(empty), 32'd1);

`ifdef SCM_FIFO_FLUSH_EN
        // Flush with 3 entries and a push offered: nothing written, everything cleared.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h41 + i), 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        #1;
        chk("flush_count_before", 0, 32'(count), 32'd3);
        chk("flush_in_ready", 0, 32'(in_ready), 32'd0);
        chk("flush_rf_we", 0, 32'(rf_we), 32'd0);
        chk("flush_rf_re", 0, 32'(rf_re), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("flush_count", 0, 32'(count), 32'd0);
        chk("flush_out_valid", 0, 32'(out_valid), 32'd0);
        chk("flush_empty", 0, 32'(empty), 32'd1);
        drive(1'b0, 1'b1, 8'h88, 1'b0);
        chk("flush_waddr", 0, 32'(rf_waddr), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_raddr", 0, 32'(rf_raddr), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("flush_out_data", 0, 32'(out_data), 32'h88);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
`endif

        // Reset mid-transfer discards contents and restarts pointers at 0.
        drive(1'b0, 1'b1, 8'h51, 1'b0);
        drive(1'b0, 1'b1, 8'h52, 1'b0);
        drive(1'b1, 1'b1, 8'h53, 1'b1);
        chk("mid_rst_in_ready", 0, 32'(in_ready), 32'd0);
        chk("mid_rst_rf_we", 0, 32'(rf_we), 32'd0);
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        chk("mid_rst_count", 0, 32'(count), 32'd0);
        chk("mid_rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("mid_rst_waddr", 0, 32'(rf_waddr), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_rst_out_valid2", 0, 32'(out_valid), 32'd1);
        chk("mid_rst_out_data", 0, 32'(out_data), 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
